systolic_nxn: RTL and testbench

Parametrised N x N output-stationary systolic matrix-multiply engine. It computes C = A x B with K-deep inner products. A-columns and B-rows stream in through a valid/ready port and are skewed internally. Results drain row-major with saturation flags through a valid/ready result port. It sits between the iobuf DMA/ibus buffers and the host, and generalises the fixed 2x2 array with its externally driven start/awe/bwe wiring.

---
 rtl/systolic_pkg.sv | 42 ++++
 rtl/systolic_pe_mac.sv | 73 +++++++
 rtl/systolic_nxn.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_systolic_nxn.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared state encoding, default widths and the saturating clamp used by the
// N x N output-stationary systolic matrix-multiply engine.
package systolic_pkg;

  localparam int DW_DEF  = 16;
  localparam int KW_DEF  = 8;
  localparam int CLAMP_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic                      sat;
    logic signed [CLAMP_W-1:0] val;
  } clamp_t;

  // Accumulators are sign-extended to CLAMP_W bits before clamping to dw bits.
  function automatic clamp_t sat_clamp(input logic signed [CLAMP_W-1:0] acc,
                                       input int unsigned dw);
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    clamp_t r;
    hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 32'd1));
    if (acc > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (acc < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end else begin
      r.sat = 1'b0;
      r.val = acc;
    end
    return r;
  endfunction

endpackage

// File: rtl/systolic_pe_mac.sv
// Single processing element: forwards a east and b south one cycle per hop and
// accumulates the full-width signed product whenever both operands are valid.
module systolic_pe_mac
  import systolic_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 2*DW_DEF+KW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic signed [DW-1:0] a_in,
  input  logic                 a_vld_in,
  input  logic signed [DW-1:0] b_in,
  input  logic                 b_vld_in,
  output logic signed [DW-1:0] a_out,
  output logic                 a_vld_out,
  output logic signed [DW-1:0] b_out,
  output logic                 b_vld_out,
  output logic signed [AW-1:0] acc
);

  logic signed [DW-1:0] a_q, a_d, b_q, b_d;
  logic                 a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] a_ext_s, b_ext_s, prod_s;

  assign a_ext_s = AW'(a_in);
  assign b_ext_s = AW'(b_in);
  assign prod_s  = a_ext_s * b_ext_s;

  always_comb begin
    a_d     = a_in;
    b_d     = b_in;
    a_vld_d = a_vld_in;
    b_vld_d = b_vld_in;
    acc_d   = acc_q;
    if (clr) begin
      a_d     = '0;
      b_d     = '0;
      a_vld_d = 1'b0;
      b_vld_d = 1'b0;
      acc_d   = '0;
    end else if (a_vld_in && b_vld_in) begin
      acc_d = acc_q + prod_s;
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      a_vld_q <= 1'b0;
      b_vld_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      acc_q   <= acc_d;
    end
  end

  assign a_out     = a_q;
  assign a_vld_out = a_vld_q;
  assign b_out     = b_q;
  assign b_vld_out = b_vld_q;
  assign acc       = acc_q;

endmodule

// File: rtl/systolic_nxn.sv
// N x N output-stationary systolic multiplier: skews operand beats into the PE
// grid, flushes the wavefront, then drains saturated results row-major.
module systolic_nxn
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = DW_DEF,
  parameter int KW = KW_DEF,
  parameter int AW = 2*DW+KW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   clr,
  input  logic [KW-1:0]          cfg_k,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_vec,
  input  logic [N*DW-1:0]        b_vec,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [DW-1:0]          res_data,
  output logic                   res_sat,
  output logic [$clog2(N)-1:0]   res_row,
  output logic [$clog2(N)-1:0]   res_col,
  output logic                   res_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int RW = $clog2(N);
  localparam int FW = $clog2(2*N);
  localparam logic [RW-1:0] LAST_IDX   = RW'(N-1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d, beat_cnt_q, beat_cnt_d;
  logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
  logic [RW-1:0]        row_q, row_d, col_q, col_d;
  logic                 res_valid_q, res_valid_d, res_last_q, res_last_d;
  logic                 res_sat_q, res_sat_d, done_q, done_d, err_q, err_d;
  logic [DW-1:0]        res_data_q, res_data_d;

  logic                 fire_s, acc_clr_s, load_s, clamp_unused_s;
  logic [RW-1:0]        nr_s, nc_s;
  logic signed [AW-1:0] acc_sel_s;
  clamp_t               clamp_s;

  logic signed [DW-1:0] a_row_s [N];
  logic signed [DW-1:0] b_col_s [N];
  logic                 v_lane_s [N];
  logic signed [DW-1:0] a_pipe_s [N][N];
  logic signed [DW-1:0] b_pipe_s [N][N];
  logic                 av_pipe_s [N][N];
  logic                 bv_pipe_s [N][N];
  logic signed [AW-1:0] acc_s [N][N];

  assign fire_s    = in_valid && (state_q == ST_LOAD) && !clr;
  assign acc_clr_s = clr || ((state_q == ST_IDLE) && start && (cfg_k != '0));

  // Lane i is delayed i cycles so that row i / column i meet at PE(i,j) together.
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_row_s[i]  = a_vec[i*DW +: DW];
      assign b_col_s[i]  = b_vec[i*DW +: DW];
      assign v_lane_s[i] = fire_s;
    end else begin : g_delay
      logic signed [DW-1:0] a_sr_q [i];
      logic signed [DW-1:0] a_sr_d [i];
      logic signed [DW-1:0] b_sr_q [i];
      logic signed [DW-1:0] b_sr_d [i];
      logic [i-1:0]         v_sr_q, v_sr_d;

      always_comb begin
        for (int s = 0; s < i; s++) begin
          a_sr_d[s] = '0;
          b_sr_d[s] = '0;
        end
        v_sr_d = '0;
        if (!clr) begin
          a_sr_d[0] = a_vec[i*DW +: DW];
          b_sr_d[0] = b_vec[i*DW +: DW];
          v_sr_d[0] = fire_s;
          for (int s = 1; s < i; s++) begin
            a_sr_d[s] = a_sr_q[s-1];
            b_sr_d[s] = b_sr_q[s-1];
            v_sr_d[s] = v_sr_q[s-1];
          end
        end else begin
          v_sr_d = '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
          v_sr_q <= '0;
        end else begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
          v_sr_q <= v_sr_d;
        end
      end

      assign a_row_s[i]  = a_sr_q[i-1];
      assign b_col_s[i]  = b_sr_q[i-1];
      assign v_lane_s[i] = v_sr_q[i-1];
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      logic signed [DW-1:0] a_in_s, b_in_s;
      logic                 av_in_s, bv_in_s;

      if (c == 0) begin : g_west
        assign a_in_s  = a_row_s[r];
        assign av_in_s = v_lane_s[r];
      end else begin : g_east
        assign a_in_s  = a_pipe_s[r][c-1];
        assign av_in_s = av_pipe_s[r][c-1];
      end

      if (r == 0) begin : g_north
        assign b_in_s  = b_col_s[c];
        assign bv_in_s = v_lane_s[c];
      end else begin : g_south
        assign b_in_s  = b_pipe_s[r-1][c];
        assign bv_in_s = bv_pipe_s[r-1][c];
      end

      systolic_pe_mac #(.DW(DW), .AW(AW)) u_pe (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr_s),
        .a_in      (a_in_s),
        .a_vld_in  (av_in_s),
        .b_in      (b_in_s),
        .b_vld_in  (bv_in_s),
        .a_out     (a_pipe_s[r][c]),
        .a_vld_out (av_pipe_s[r][c]),
        .b_out     (b_pipe_s[r][c]),
        .b_vld_out (bv_pipe_s[r][c]),
        .acc       (acc_s[r][c])
      );
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    beat_cnt_d  = beat_cnt_q;
    flush_cnt_d = flush_cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    res_valid_d = res_valid_q;
    res_last_d  = res_last_q;
    res_sat_d   = res_sat_q;
    res_data_d  = res_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load_s      = 1'b0;
    nr_s        = row_q;
    nc_s        = col_q;
    acc_sel_s   = '0;
    clamp_s     = '0;

    if (clr) begin
      state_d     = ST_IDLE;
      beat_cnt_d  = '0;
      flush_cnt_d = '0;
      row_d       = '0;
      col_d       = '0;
      res_valid_d = 1'b0;
      res_last_d  = 1'b0;
      res_sat_d   = 1'b0;
      res_data_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && (cfg_k == '0)) begin
            err_d = 1'b1;
          end else if (start) begin
            state_d    = ST_LOAD;
            k_d        = cfg_k;
            beat_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (fire_s) begin
            beat_cnt_d = beat_cnt_q + KW'(1);
            if (beat_cnt_d == k_q) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = '0;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d     = ST_DRAIN;
            res_valid_d = 1'b1;
            load_s      = 1'b1;
            nr_s        = '0;
            nc_s        = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + FW'(1);
          end
        end
        ST_DRAIN: begin
          if (res_ready && res_last_q) begin
            state_d     = ST_IDLE;
            done_d      = 1'b1;
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            res_sat_d   = 1'b0;
            res_data_d  = '0;
            row_d       = '0;
            col_d       = '0;
          end else if (res_ready) begin
            load_s = 1'b1;
            if (col_q == LAST_IDX) begin
              nc_s = '0;
              nr_s = row_q + RW'(1);
            end else begin
              nc_s = col_q + RW'(1);
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The result register is loaded with the element the index is moving to.
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if ((nr_s == RW'(r)) && (nc_s == RW'(c))) begin
          acc_sel_s = acc_s[r][c];
        end else begin
          acc_sel_s = acc_sel_s;
        end
      end
    end
    clamp_s = sat_clamp(CLAMP_W'(acc_sel_s), DW);

    if (load_s) begin
      row_d      = nr_s;
      col_d      = nc_s;
      res_data_d = clamp_s.val[DW-1:0];
      res_sat_d  = clamp_s.sat;
      res_last_d = (nr_s == LAST_IDX) && (nc_s == LAST_IDX);
    end else begin
      row_d = row_d;
    end
  end

  assign clamp_unused_s = ^clamp_s.val[CLAMP_W-1:DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      col_q       <= '0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      res_sat_q   <= 1'b0;
      res_data_q  <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      beat_cnt_q  <= beat_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      res_valid_q <= res_valid_d;
      res_last_q  <= res_last_d;
      res_sat_q   <= res_sat_d;
      res_data_q  <= res_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_sat   = res_sat_q;
  assign res_row   = row_q;
  assign res_col   = col_q;
  assign res_last  = res_last_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_systolic_nxn.sv
// Scoreboard bench for systolic_nxn (N=4): directed jobs push expected result
// beats; a negedge monitor pops and compares on each result handshake.
module tb_systolic_nxn;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            rst, start, clr, in_valid, res_ready;
  logic [KW-1:0]   cfg_k;
  logic [N*DW-1:0] a_vec, b_vec;
  logic            in_ready, res_valid, res_sat, res_last, busy, done, err;
  logic [DW-1:0]   res_data;
  logic [1:0]      res_row, res_col;

  systolic_nxn #(.N(N), .DW(DW), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .cfg_k(cfg_k),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_sat(res_sat), .res_row(res_row), .res_col(res_col),
    .res_last(res_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sat;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t snap;
  bit   stalled  = 1'b0;
  bit   exp_done = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*DW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
    logic [N*DW-1:0] r;
    r[0*DW +: DW] = DW'(v0);
    r[1*DW +: DW] = DW'(v1);
    r[2*DW +: DW] = DW'(v2);
    r[3*DW +: DW] = DW'(v3);
    return r;
  endfunction

  task automatic push_mat(input int c[16], input logic [15:0] satm);
    exp_t e;
    for (int idx = 0; idx < 16; idx++) begin
      e.data = DW'(c[idx]);
      e.sat  = satm[idx];
      e.row  = 2'(idx / 4);
      e.col  = 2'(idx % 4);
      e.last = (idx == 15);
      sb_q.push_back(e);
    end
  endtask

  task automatic start_job(input logic [KW-1:0] k);
    cfg_k = k;
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_k = '0;
  endtask

  task automatic beat(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    a_vec    = a;
    b_vec    = b;
    in_valid = 1'b1;
    step();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", budget);
    end
    step();
    step();
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!res_valid) begin
      errors++;
      $display("FAIL wait_valid: res_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  // Monitor: done tracking, stall stability and scoreboard comparison.
  always @(negedge clk) begin
    if (rst) begin
      stalled  = 1'b0;
      exp_done = 1'b0;
    end else begin
      check("done_pulse", done, exp_done);
      if (stalled && res_valid)
        check("stall_hold", {res_data, res_sat, res_row, res_col, res_last},
              {snap.data, snap.sat, snap.row, snap.col, snap.last});
      if (res_valid && res_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h row %0d col %0d, required none", res_data, res_row, res_col);
        end else begin
          mon_e = sb_q.pop_front();
          check("result_beat", {res_data, res_sat, res_row, res_col, res_last},
                {mon_e.data, mon_e.sat, mon_e.row, mon_e.col, mon_e.last});
        end
        stalled = 1'b0;
      end else if (res_valid) begin
        stalled   = 1'b1;
        snap.data = res_data;
        snap.sat  = res_sat;
        snap.row  = res_row;
        snap.col  = res_col;
        snap.last = res_last;
      end else begin
        stalled = 1'b0;
      end
      exp_done = res_valid && res_ready && res_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c[16];
    rst = 1'b1; start = 1'b0; clr = 1'b0; cfg_k = '0; in_valid = 1'b0;
    a_vec = '0; b_vec = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {res_valid, res_data, res_sat, res_row, res_col, res_last, busy, done, err, in_ready}, 64'd0);
    rst = 1'b0;
    step();

    // Basic 2x2 product embedded in the top-left corner.
    c = '{19, 22, 0, 0, 43, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    push_mat(c, 16'h0000);
    start_job(8'd2);
    check("in_ready_load", {busy, in_ready}, 64'b11);
    beat(pack4(1, 3, 0, 0), pack4(5, 6, 0, 0));
    beat(pack4(2, 4, 0, 0), pack4(7, 8, 0, 0));
    in_valid = 1'b0;
    wait_idle(100);

    // Saturation in both directions.
    c = '{32767, 200, 0, 0, -32768, -200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    push_mat(c, 16'h0011);
    start_job(8'd1);
    beat(pack4(200, -200, 0, 0), pack4(200, 1, 0, 0));
    in_valid = 1'b0;
    wait_idle(100);

    // Identity times B with bubbles, an ignored start, and result backpressure.
    for (int i = 0; i < 16; i++) c[i] = i;
    push_mat(c, 16'h0000);
    start_job(8'd4);
    for (int k = 0; k < 4; k++) begin
      beat(pack4(int'(k == 0), int'(k == 1), int'(k == 2), int'(k == 3)),
           pack4(4*k, 4*k+1, 4*k+2, 4*k+3));
      if (k < 3) begin
        in_valid = 1'b0;
        if (k == 1) begin
          cfg_k = 8'd1;
          start = 1'b1;
        end
        step();
        start = 1'b0;
        cfg_k = '0;
        if (k == 1) check("ignored_start", {busy, err}, 64'b10);
      end
    end
    in_valid = 1'b0;
    wait_valid(100);
    repeat (3) step();
    res_ready = 1'b0;
    repeat (3) step();
    res_ready = 1'b1;
    wait_idle(200);

    // Illegal start with K=0.
    start_job(8'd0);
    check("err_pulse", {err, busy}, 64'b10);
    step();
    check("err_clears", {err, busy}, 64'b00);

    // Abort in FLUSH, then a fresh job must show no stale accumulation.
    start_job(8'd2);
    beat(pack4(100, 100, 100, 100), pack4(100, 100, 100, 100));
    beat(pack4(100, 100, 100, 100), pack4(100, 100, 100, 100));
    in_valid = 1'b0;
    check("in_flush", {busy, in_ready}, 64'b10);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_to_idle", busy, 64'd0);
    repeat (12) step();
    check("clr_no_results", {res_valid, busy}, 64'd0);
    for (int i = 0; i < 16; i++) c[i] = 1;
    push_mat(c, 16'h0000);
    start_job(8'd1);
    beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    in_valid = 1'b0;
    wait_idle(100);

    // Asynchronous reset while a result is held.
    res_ready = 1'b0;
    start_job(8'd1);
    beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
    in_valid = 1'b0;
    wait_valid(100);
    check("drain_held", {res_valid, busy, res_data}, {1'b1, 1'b1, 16'd1});
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {res_valid, res_data, res_sat, res_row, res_col, res_last, busy, done, err, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    res_ready = 1'b1;
    repeat (3) step();
    check("after_reset", {busy, res_valid}, 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
